// File: rtl/stock_card_dispenser.sv
// Reader end of the stock pile: presents the top card with a valid/ack/nack
// handshake and removes it only when the placement logic accepts it.
module stock_card_dispenser #(
  parameter int CARD_SIZE  = 7,
  parameter int PILE_DEPTH = 24,
  parameter int SIZE_W     = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [PILE_DEPTH*CARD_SIZE-1:0]  stock_pile_in,
  input  logic [SIZE_W-1:0]                stock_size_in,
  input  logic                             pop_req,
  input  logic                             card_ack,
  input  logic                             card_nack,
  output logic [CARD_SIZE-1:0]             card_out,
  output logic                             card_valid,
  output logic [PILE_DEPTH*CARD_SIZE-1:0]  stock_pile,
  output logic [SIZE_W-1:0]                stock_size,
  output logic                             empty,
  output logic                             busy,
  output logic                             underflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t state, state_nxt;
  logic [PILE_DEPTH-1:0][CARD_SIZE-1:0] slots;
  logic [SIZE_W-1:0] top_idx, load_size;
  logic do_present, do_under, do_release, do_remove;

  assign top_idx   = stock_size - SIZE_W'(1);
  assign load_size = (stock_size_in > SIZE_W'(PILE_DEPTH)) ? SIZE_W'(PILE_DEPTH) : stock_size_in;
  assign empty     = (stock_size == '0);
  assign busy      = (state != IDLE);
  assign stock_pile = slots;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // load overrides every handshake; nack beats ack so a conflict never removes a card
  always_comb begin
    state_nxt  = state;
    do_present = 1'b0;
    do_under   = 1'b0;
    do_release = 1'b0;
    do_remove  = 1'b0;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (pop_req) begin
          if (empty) do_under = 1'b1;
          else begin
            do_present = 1'b1;
            state_nxt  = PRESENT;
          end
        end
        PRESENT: if (card_ack || card_nack) begin
          do_release = 1'b1;
          do_remove  = !card_nack;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots      <= '0;
      stock_size <= '0;
      card_out   <= '0;
      card_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      underflow <= do_under;
      if (load) begin
        slots      <= stock_pile_in;
        stock_size <= load_size;
        card_out   <= '0;
        card_valid <= 1'b0;
      end else begin
        if (do_present) begin
          card_out   <= slots[top_idx];
          card_valid <= 1'b1;
        end
        if (do_release) begin
          card_out   <= '0;
          card_valid <= 1'b0;
        end
        if (do_remove) begin
          slots[top_idx] <= '0;
          stock_size     <= top_idx;
        end
      end
    end
  end

endmodule
